// File: rtl/reg_debug_port.sv
// Byte-serial debug port for the 16x8 register file: write, read and dump
// commands arrive on an rx byte stream, read data leaves on a tx byte stream.
module reg_debug_port (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       rx_ready,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic [3:0] rf_ra,
  input  logic [7:0] rf_read,
  output logic [3:0] rf_wa,
  output logic [7:0] rf_wd,
  output logic       rf_we,
  output logic       halt,
  output logic       err
);

  typedef enum logic [2:0] {IDLE, GET_DATA, WRITE, LOAD, SEND} state_t;

  localparam logic [3:0] OP_WR   = 4'h1;
  localparam logic [3:0] OP_RD   = 4'h2;
  localparam logic [3:0] OP_DUMP = 4'h3;

  state_t     state, state_nxt;
  logic [3:0] addr, ptr;
  logic [7:0] data;
  logic       dump;
  logic [3:0] op;
  logic       known_op;

  assign op       = rx_data[7:4];
  assign known_op = (op == OP_WR) || (op == OP_RD) || (op == OP_DUMP);

  // Strobes are gated with rst so nothing leaks to the core or register file
  // while reset is held, even if reset lands mid-command.
  always_comb begin
    state_nxt = state;
    rx_ready  = 1'b0;
    halt      = !rst;
    rf_we     = 1'b0;
    rf_wa     = 4'h0;
    rf_wd     = 8'h00;
    rf_ra     = ptr;
    case (state)
      IDLE: begin
        rx_ready = !rst;
        halt     = !rst && rx_valid && known_op;
        if (rx_valid && !rst) begin
          case (op)
            OP_WR:          state_nxt = GET_DATA;
            OP_RD, OP_DUMP: state_nxt = LOAD;
            default:        state_nxt = IDLE;
          endcase
        end
      end
      GET_DATA: begin
        rx_ready = !rst;
        if (rx_valid) state_nxt = WRITE;
      end
      WRITE: begin
        rf_we     = !rst;
        rf_wa     = addr;
        rf_wd     = data;
        state_nxt = IDLE;
      end
      LOAD: state_nxt = SEND;
      SEND: begin
        if (tx_ready) state_nxt = (dump && ptr != 4'hF) ? LOAD : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      addr     <= 4'h0;
      data     <= 8'h00;
      ptr      <= 4'h0;
      dump     <= 1'b0;
      tx_data  <= 8'h00;
      tx_valid <= 1'b0;
      err      <= 1'b0;
    end else begin
      state <= state_nxt;
      err   <= 1'b0;
      case (state)
        IDLE: begin
          if (rx_valid) begin
            addr <= rx_data[3:0];
            case (op)
              OP_WR: ;
              OP_RD: begin
                ptr  <= rx_data[3:0];
                dump <= 1'b0;
              end
              OP_DUMP: begin
                ptr  <= 4'h0;
                dump <= 1'b1;
              end
              default: err <= 1'b1;
            endcase
          end
        end
        GET_DATA: if (rx_valid) data <= rx_data;
        LOAD: begin
          tx_data  <= rf_read;
          tx_valid <= 1'b1;
        end
        SEND: begin
          // ptr stops at 15 so a dump never wraps back to r0
          if (tx_ready) begin
            tx_valid <= 1'b0;
            if (dump && ptr != 4'hF) ptr <= ptr + 4'h1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_debug_port.sv
// Bench for reg_debug_port: directed scenarios plus a random command mix
// checked against a behavioural register-file/stream model.
module tb_reg_debug_port;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       tx_ready = 1'b0;
  logic       rx_ready, tx_valid, rf_we, halt, err;
  logic [7:0] tx_data, rf_read, rf_wd;
  logic [3:0] rf_ra, rf_wa;

  reg_debug_port dut (
    .clk(clk), .rst(rst),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rf_ra(rf_ra), .rf_read(rf_read),
    .rf_wa(rf_wa), .rf_wd(rf_wd), .rf_we(rf_we),
    .halt(halt), .err(err)
  );

  always #5 clk = ~clk;

  // Register file the port drives; r0 is hardwired to zero.
  logic [7:0] rf_mem [16];
  always @(posedge clk) begin
    if (rst) for (int i = 0; i < 16; i++) rf_mem[i] <= 8'h00;
    else if (rf_we && rf_wa != 4'h0) rf_mem[rf_wa] <= rf_wd;
  end
  assign rf_read = (rf_ra == 4'h0) ? 8'h00 : rf_mem[rf_ra];

  // Observed traffic, sampled mid-cycle.
  logic [7:0]  tx_q [$];
  logic [11:0] we_q [$];
  int          err_cnt = 0;
  always @(negedge clk) begin
    if (!rst) begin
      if (tx_valid && tx_ready) tx_q.push_back(tx_data);
      if (rf_we) we_q.push_back({rf_wa, rf_wd});
      if (err) err_cnt++;
    end
  end

  // Reference model: register contents and the expected traffic history.
  logic [7:0]  m_rf [16];
  logic [7:0]  m_tx [$];
  logic [11:0] m_we [$];
  int          m_err = 0;
  int          errors = 0;
  int          checks = 0;

  task automatic m_reset();
    for (int i = 0; i < 16; i++) m_rf[i] = 8'h00;
  endtask
  task automatic m_write(input logic [3:0] a, input logic [7:0] d);
    m_we.push_back({a, d});
    if (a != 4'h0) m_rf[a] = d;
  endtask
  task automatic m_read(input logic [3:0] a);
    m_tx.push_back(m_rf[a]);
  endtask
  task automatic m_dump(input int n);
    for (int i = 0; i < n; i++) m_tx.push_back(m_rf[i]);
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Present a byte and hold it until the port takes it; returns just after that edge.
  task automatic send_byte(input logic [7:0] b);
    bit ok = 1'b0;
    rx_data  = b;
    rx_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (rx_ready) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL rx_accept: byte %h not accepted, rx_ready=%b want 1", b, rx_ready); end
    step();
    rx_valid = 1'b0;
  endtask

  task automatic wait_idle(input bit rnd);
    bit ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (!halt && !tx_valid) begin ok = 1'b1; break; end
      step();
      if (rnd) tx_ready = 1'($urandom_range(0, 1));
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL idle_timeout: halt=%b tx_valid=%b want 0/0", halt, tx_valid); end
    step();
  endtask

  task automatic test_reset();
    step(); step();
    rx_data = 8'h15; rx_valid = 1'b1;
    @(negedge clk);
    checks++;
    if ({rx_ready, tx_valid, rf_we, err, halt} !== 5'b0) begin
      errors++; $display("FAIL reset_hold: rdy/txv/we/err/halt=%b want 00000", {rx_ready, tx_valid, rf_we, err, halt});
    end
    step();
    rx_valid = 1'b0; rst = 1'b0;
    m_reset();
    @(negedge clk);
    checks++;
    if ({rx_ready, tx_valid, halt, err} !== 4'b1000 || tx_data !== 8'h00) begin
      errors++; $display("FAIL reset_release: rdy/txv/halt/err=%b tx_data=%h want 1000 00", {rx_ready, tx_valid, halt, err}, tx_data);
    end
    step();
  endtask

  task automatic test_write_read();
    int tb = tx_q.size();
    tx_ready = 1'b1;
    send_byte(8'h15);
    send_byte(8'hA7);
    @(negedge clk);
    checks++;
    if (rf_we !== 1'b1 || rf_wa !== 4'h5 || rf_wd !== 8'hA7 || rx_ready !== 1'b0) begin
      errors++; $display("FAIL wr_pulse: we=%b wa=%h wd=%h rdy=%b want 1 5 a7 0", rf_we, rf_wa, rf_wd, rx_ready);
    end
    step();
    m_write(4'h5, 8'hA7);
    @(negedge clk);
    checks++;
    if (rf_we !== 1'b0 || halt !== 1'b0 || rx_ready !== 1'b1) begin
      errors++; $display("FAIL wr_done: we=%b halt=%b rdy=%b want 0 0 1", rf_we, halt, rx_ready);
    end
    step();
    send_byte(8'h25);
    @(negedge clk);
    checks++;
    if (tx_valid !== 1'b0 || halt !== 1'b1 || rf_ra !== 4'h5) begin
      errors++; $display("FAIL rd_load: txv=%b halt=%b ra=%h want 0 1 5", tx_valid, halt, rf_ra);
    end
    step();
    @(negedge clk);
    checks++;
    if (tx_valid !== 1'b1 || tx_data !== 8'hA7) begin
      errors++; $display("FAIL rd_send: txv=%b data=%h want 1 a7", tx_valid, tx_data);
    end
    step();
    m_read(4'h5);
    @(negedge clk);
    checks++;
    if (tx_valid !== 1'b0 || halt !== 1'b0 || tx_q.size() != tb + 1) begin
      errors++; $display("FAIL rd_done: txv=%b halt=%b bytes=%0d want 0 0 1", tx_valid, halt, tx_q.size() - tb);
    end
    step();
  endtask

  task automatic test_r0();
    int wb = we_q.size();
    int tb = tx_q.size();
    tx_ready = 1'b1;
    send_byte(8'h10);
    send_byte(8'hFF);
    wait_idle(1'b0);
    m_write(4'h0, 8'hFF);
    send_byte(8'h20);
    wait_idle(1'b0);
    m_read(4'h0);
    checks++;
    if (we_q.size() != wb + 1 || we_q[wb] !== 12'h0FF) begin
      errors++; $display("FAIL r0_write: writes=%0d first=%h want 1 0ff", we_q.size() - wb, we_q[wb]);
    end
    checks++;
    if (tx_q.size() != tb + 1 || tx_q[tb] !== 8'h00) begin
      errors++; $display("FAIL r0_read: bytes=%0d data=%h want 1 00", tx_q.size() - tb, tx_q[tb]);
    end
  endtask

  task automatic test_dump();
    int tb;
    for (int n = 1; n < 16; n++) begin
      send_byte({4'h1, 4'(n)});
      send_byte(8'h10 + 8'(n));
      wait_idle(1'b0);
      m_write(4'(n), 8'h10 + 8'(n));
    end
    tx_ready = 1'b1;
    tb = tx_q.size();
    send_byte(8'h3A);
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      checks++;
      if (halt !== 1'b1 || tx_valid !== 1'(k % 2)) begin
        errors++; $display("FAIL dump_cycle%0d: halt=%b txv=%b want 1 %0d", k, halt, tx_valid, k % 2);
      end
      step();
    end
    @(negedge clk);
    checks++;
    if (halt !== 1'b0 || rx_ready !== 1'b1 || tx_valid !== 1'b0) begin
      errors++; $display("FAIL dump_end: halt=%b rdy=%b txv=%b want 0 1 0", halt, rx_ready, tx_valid);
    end
    step();
    m_dump(16);
    checks++;
    if (tx_q.size() != tb + 16) begin
      errors++; $display("FAIL dump_count: bytes=%0d want 16", tx_q.size() - tb);
    end else begin
      for (int i = 0; i < 16; i++) begin
        checks++;
        if (tx_q[tb + i] !== ((i == 0) ? 8'h00 : 8'h10 + 8'(i))) begin
          errors++; $display("FAIL dump_byte%0d: got %h want %h", i, tx_q[tb + i], (i == 0) ? 8'h00 : 8'h10 + 8'(i));
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int tb = tx_q.size();
    logic [7:0] exp = m_rf[3];
    tx_ready = 1'b0;
    send_byte(8'h23);
    step();
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      checks++;
      if (tx_valid !== 1'b1 || tx_data !== exp || halt !== 1'b1) begin
        errors++; $display("FAIL bp_stall%0d: txv=%b data=%h halt=%b want 1 %h 1", k, tx_valid, tx_data, halt, exp);
      end
      step();
    end
    tx_ready = 1'b1;
    step();
    @(negedge clk);
    checks++;
    if (tx_valid !== 1'b0 || halt !== 1'b0) begin
      errors++; $display("FAIL bp_done: txv=%b halt=%b want 0 0", tx_valid, halt);
    end
    step();
    m_read(4'h3);
    checks++;
    if (tx_q.size() != tb + 1 || tx_q[tb] !== exp) begin
      errors++; $display("FAIL bp_bytes: count=%0d data=%h want 1 %h", tx_q.size() - tb, tx_q[tb], exp);
    end
  endtask

  task automatic test_bad_opcode();
    int eb = err_cnt, wb = we_q.size(), tb = tx_q.size();
    tx_ready = 1'b1;
    rx_data = 8'h50; rx_valid = 1'b1;
    @(negedge clk);
    checks++;
    if (halt !== 1'b0 || rx_ready !== 1'b1) begin
      errors++; $display("FAIL bad_accept: halt=%b rdy=%b want 0 1", halt, rx_ready);
    end
    step();
    rx_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (err !== 1'b1 || halt !== 1'b0 || rx_ready !== 1'b1) begin
      errors++; $display("FAIL bad_err: err=%b halt=%b rdy=%b want 1 0 1", err, halt, rx_ready);
    end
    step();
    m_err++;
    @(negedge clk);
    checks++;
    if (err !== 1'b0 || err_cnt != eb + 1 || we_q.size() != wb || tx_q.size() != tb) begin
      errors++; $display("FAIL bad_after: err=%b pulses=%0d writes=%0d bytes=%0d want 0 1 0 0", err, err_cnt - eb, we_q.size() - wb, tx_q.size() - tb);
    end
    step();
  endtask

  task automatic test_stalled_data();
    rx_data = 8'h14; rx_valid = 1'b1;
    @(negedge clk);
    checks++;
    if (halt !== 1'b1) begin errors++; $display("FAIL stall_halt_accept: halt=%b want 1", halt); end
    step();
    rx_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if (rf_we !== 1'b0 || rx_ready !== 1'b1 || halt !== 1'b1) begin
        errors++; $display("FAIL stall_wait%0d: we=%b rdy=%b halt=%b want 0 1 1", k, rf_we, rx_ready, halt);
      end
      step();
    end
    send_byte(8'h3C);
    @(negedge clk);
    checks++;
    if (rf_we !== 1'b1 || rf_wa !== 4'h4 || rf_wd !== 8'h3C) begin
      errors++; $display("FAIL stall_write: we=%b wa=%h wd=%h want 1 4 3c", rf_we, rf_wa, rf_wd);
    end
    step();
    m_write(4'h4, 8'h3C);
  endtask

  task automatic test_reset_mid_dump();
    int tb = tx_q.size();
    int cnt = 0;
    tx_ready = 1'b1;
    send_byte(8'h30);
    for (int i = 0; i < 100 && cnt < 4; i++) begin
      @(negedge clk);
      if (tx_valid && tx_ready) cnt++;
      step();
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    m_dump(4);
    m_reset();
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checks++;
      if (tx_valid !== 1'b0 || halt !== 1'b0 || rx_ready !== 1'b1) begin
        errors++; $display("FAIL rst_dump%0d: txv=%b halt=%b rdy=%b want 0 0 1", k, tx_valid, halt, rx_ready);
      end
      step();
    end
    checks++;
    if (tx_q.size() != tb + 4) begin
      errors++; $display("FAIL rst_dump_count: bytes=%0d want 4", tx_q.size() - tb);
    end
    // Reset while a byte is pending must drop it, not resend it.
    tb = tx_q.size();
    tx_ready = 1'b0;
    send_byte(8'h23);
    step();
    @(negedge clk);
    checks++;
    if (tx_valid !== 1'b1) begin errors++; $display("FAIL rst_send_pre: txv=%b want 1", tx_valid); end
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    tx_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if (tx_valid !== 1'b0 || halt !== 1'b0) begin
        errors++; $display("FAIL rst_send%0d: txv=%b halt=%b want 0 0", k, tx_valid, halt);
      end
      step();
    end
    checks++;
    if (tx_q.size() != tb) begin errors++; $display("FAIL rst_send_bytes: bytes=%0d want 0", tx_q.size() - tb); end
  endtask

  task automatic test_random();
    logic [3:0] a, op;
    logic [7:0] d;
    for (int n = 0; n < 60; n++) begin
      a = 4'($urandom_range(0, 15));
      d = 8'($urandom_range(0, 255));
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4: begin
          send_byte({4'h1, a}); send_byte(d); wait_idle(1'b1); m_write(a, d);
        end
        5, 6, 7: begin
          tx_ready = 1'($urandom_range(0, 1));
          send_byte({4'h2, a}); wait_idle(1'b1); m_read(a);
        end
        8: begin
          op = 4'($urandom_range(0, 12));
          if (op != 4'h0) op = op + 4'h3;
          send_byte({op, a}); wait_idle(1'b1); m_err++;
        end
        default: begin
          tx_ready = 1'($urandom_range(0, 1));
          send_byte({4'h3, a}); wait_idle(1'b1); m_dump(16);
        end
      endcase
    end
    step();
    checks++;
    if (tx_q.size() != m_tx.size()) begin
      errors++; $display("FAIL rand_tx_count: got %0d want %0d", tx_q.size(), m_tx.size());
    end else begin
      for (int i = 0; i < m_tx.size(); i++) begin
        checks++;
        if (tx_q[i] !== m_tx[i]) begin errors++; $display("FAIL rand_tx%0d: got %h want %h", i, tx_q[i], m_tx[i]); end
      end
    end
    checks++;
    if (we_q.size() != m_we.size()) begin
      errors++; $display("FAIL rand_we_count: got %0d want %0d", we_q.size(), m_we.size());
    end else begin
      for (int i = 0; i < m_we.size(); i++) begin
        checks++;
        if (we_q[i] !== m_we[i]) begin errors++; $display("FAIL rand_we%0d: got %h want %h", i, we_q[i], m_we[i]); end
      end
    end
    checks++;
    if (err_cnt != m_err) begin errors++; $display("FAIL rand_err_count: got %0d want %0d", err_cnt, m_err); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_r0();
    test_dump();
    test_backpressure();
    test_bad_opcode();
    test_stalled_data();
    test_reset_mid_dump();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule

// File: doc/reg_debug_port.md
# reg_debug_port

Byte-serial debug/bring-up port for the 8-bit core's 16×8 register file. It accepts command bytes over a valid/ready receive stream and drives the register file's write port (`rf_wa`, `rf_wd`, `rf_we`) and one read port (`rf_ra`, `rf_read`). Read results go out on a valid/ready transmit stream. It sits between the host link (UART byte layer) and the register file. While a command is in progress it asserts `halt` so the core stays off the register file.

## Interface
- No parameters. Register count is fixed at 16 and data width at 8.
- `clk` in 1: sole clock; all state changes on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `rx_data` in 8: command or data byte from the host link.
- `rx_valid` in 1: `rx_data` is valid.
- `rx_ready` out 1: the block accepts `rx_data` this cycle.
- `tx_data` out 8: register contents sent to the host link.
- `tx_valid` out 1: `tx_data` is valid; held until accepted.
- `tx_ready` in 1: the host link accepts `tx_data`.
- `rf_ra` out 4: register file read address.
- `rf_read` in 8: register file read data. It is combinational from `rf_ra`, and r0 reads 0.
- `rf_wa` out 4: register file write address.
- `rf_wd` out 8: register file write data.
- `rf_we` out 1: register file write enable.
- `halt` out 1: high while any command is in progress; the core must not access the register file.
- `err` out 1: one-cycle pulse when an unknown opcode is received.

## Operation
- Command byte layout: opcode = `rx_data[7:4]`, address = `rx_data[3:0]`.
  - 0x1: write register. The next received byte is the data.
  - 0x2: read one register.
  - 0x3: dump all registers r0..r15; the address field is ignored.
  - Any other opcode: the byte is dropped, `err` pulses, and the block stays in IDLE.
- State machine states: IDLE, GET_DATA, WRITE, LOAD, SEND.
- Registered fields: `addr` (4 bits), `data` (8 bits), `ptr` (4 bits), `dump` flag.
- IDLE:
  - `rx_ready`=1.
  - On `rx_valid`, latch `addr`.
  - Opcode 0x1 → GET_DATA.
  - Opcode 0x2 → LOAD, with `ptr`=`addr` and `dump`=0.
  - Opcode 0x3 → LOAD, with `ptr`=0 and `dump`=1.
- GET_DATA: `rx_ready`=1. On `rx_valid`, latch `data` and go to WRITE.
- WRITE:
  - `rf_we`=1, `rf_wa`=`addr`, `rf_wd`=`data` for exactly one cycle, then IDLE.
  - A write to r0 is still issued; the register file discards it.
- LOAD:
  - `rf_ra`=`ptr`.
  - At the clock edge: `tx_data` ← `rf_read`, `tx_valid` ← 1, go to SEND.
- SEND:
  - Hold `tx_data` and `tx_valid` until `tx_ready`.
  - On handshake: `tx_valid` ← 0.
  - If `dump`=1 and `ptr`≠15: `ptr` ← `ptr`+1 and go to LOAD.
  - Otherwise go to IDLE.
  - `ptr` never wraps: a dump ends after r15.
- Output defaults when not stated:
  - `rx_ready`=0 outside IDLE and GET_DATA.
  - `rf_we`=0, `rf_wa`=0, `rf_wd`=0 outside WRITE.
  - `rf_ra`=`ptr` in all states.
- `halt`=1 in every state except IDLE. It is also 1 in the IDLE cycle that accepts a valid opcode 0x1/0x2/0x3 (combinational), so the core is held from the accepting cycle onward.
- `rx_valid` while `rx_ready`=0 is ignored; the host must hold the byte.

## Timing
- Reset values:
  - State IDLE; `addr`, `data`, `ptr`, `dump` = 0.
  - `tx_valid`=0, `tx_data`=0x00, `rf_we`=0, `err`=0, `halt`=0.
  - `rx_ready`=0 while `rst` is high and 1 in the first cycle after release.
- Reset mid-operation aborts the command: no `rf_we`, `tx_valid` drops on the next edge, no partial byte is retransmitted.
- Write latency:
  - Data byte accepted at edge T → `rf_we` high during cycle T..T+1.
  - The register is updated at edge T+1.
  - `rx_ready` is high again after edge T+1.
- Read latency:
  - Command accepted at edge T → LOAD during T..T+1 → `tx_valid` high from edge T+1.
  - Minimum of 2 cycles per byte.
- Dump with `tx_ready` held at 1: 16 bytes in 32 cycles, with `tx_valid` high on alternate cycles.
- Back-pressure: `tx_data` is stable while `tx_valid`=1 and `tx_ready`=0, for any stall length.
- `err` pulses in the cycle after the bad byte is accepted. The next byte can be accepted in that same cycle.

## Test plan
- Write then read:
  - Stimulus: rx 0x15, 0xA7, then rx 0x25, with `tx_ready`=1.
  - Required: one `rf_we` pulse with `rf_wa`=5, `rf_wd`=0xA7; then tx byte 0xA7.
  - Required: `halt` is low between the two commands.
- r0 guard:
  - Stimulus: rx 0x10, 0xFF, then 0x20.
  - Required: `rf_we` pulses with `rf_wa`=0; the tx byte is 0x00.
- Full dump:
  - Stimulus: preload rN = 0x10+N, then rx 0x30 with `tx_ready`=1.
  - Required: 16 tx bytes 0x00, 0x11, …, 0x1F in 32 cycles; `halt` high throughout; IDLE after r15.
- Back-pressure:
  - Stimulus: rx 0x23 with `tx_ready`=0 for 7 cycles, then 1.
  - Required: `tx_valid` and `tx_data`=r3 held stable for the whole stall; exactly one byte transferred.
- Bad opcode, stall, reset mid-dump:
  - Bad opcode: rx 0x50 → `err` pulses for 1 cycle, no `rf_we`, no tx.
  - Stalled data: rx 0x14 with `rx_valid` low for 5 cycles → no `rf_we` until the data byte arrives.
  - Reset mid-dump: `rst` asserted after the 4th dump byte → `tx_valid`=0 next cycle, IDLE, `halt`=0.
